// File: rtl/ws2812b_frame_ctrl.sv
// WS2812B frame controller: pixel buffer, frame sequencer and auto-refresh timer feeding a bit serializer.
// Optional WS2812B_DOUBLE_BUFFER_EN: writes land in a back buffer that is copied to the front on commit.
module ws2812b_frame_ctrl #(
    parameter int unsigned LED_COUNT    = 12,
    parameter int unsigned RESET_CYCLES = 1200,
    parameter int unsigned FRAME_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [23:0] wr_data,
    input  logic        commit,
    output logic [23:0] px_data,
    output logic        px_valid,
    input  logic        px_ready,
    output logic        latch,
    output logic        busy,
    output logic        frame_done
);
    localparam int unsigned   TW         = $clog2(FRAME_CYCLES);
    localparam int unsigned   LW         = $clog2(RESET_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(FRAME_CYCLES - 1);
    localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_CYCLES - 1);
    localparam logic [3:0]    IDX_LAST   = 4'(LED_COUNT - 1);

    typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

    state_t        r_state;
    logic [3:0]    r_idx;
    logic [TW-1:0] r_timer;
    logic [LW-1:0] r_lcnt;
    logic          r_refresh_pend;
    logic          r_commit_pend;
    logic [23:0]   r_px_data;
    logic          r_px_valid;
    logic          r_latch;
    logic          r_busy;
    logic          r_frame_done;

    logic [23:0]   r_front [LED_COUNT];
`ifdef WS2812B_DOUBLE_BUFFER_EN
    logic [23:0]   r_back [LED_COUNT];
    logic          w_copy;
`endif

    logic          w_wr_ok;
    logic          w_wrap;
    logic          w_start;
    logic [3:0]    w_next_idx;
    logic [3:0]    w_rd_idx;
    logic [23:0]   w_rd_data;

    assign w_wr_ok    = wr_en && ({28'd0, wr_addr} < LED_COUNT);
    assign w_wrap     = (r_timer == TIMER_LAST);
    assign w_start    = (r_state == IDLE) && (r_refresh_pend || r_commit_pend || commit);
    assign w_next_idx = r_idx + 4'd1;
    assign w_rd_idx   = w_start ? 4'd0 : w_next_idx;
`ifdef WS2812B_DOUBLE_BUFFER_EN
    assign w_copy     = w_start && (r_commit_pend || commit);
`endif

    // Reads see the pre-edge array contents, so same-cycle writes appear only on a later load.
    always_comb begin
        w_rd_data = r_front[w_rd_idx];
`ifdef WS2812B_DOUBLE_BUFFER_EN
        if (w_copy) begin
            w_rd_data = r_back[0];
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LED_COUNT; i++) begin
                r_front[i] <= '0;
`ifdef WS2812B_DOUBLE_BUFFER_EN
                r_back[i]  <= '0;
`endif
            end
        end else begin
`ifdef WS2812B_DOUBLE_BUFFER_EN
            if (w_copy) begin
                for (int unsigned i = 0; i < LED_COUNT; i++) begin
                    r_front[i] <= r_back[i];
                end
            end
            if (w_wr_ok) begin
                r_back[wr_addr] <= wr_data;
            end
`else
            if (w_wr_ok) begin
                r_front[wr_addr] <= wr_data;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_timer        <= '0;
            r_lcnt         <= '0;
            r_refresh_pend <= 1'b0;
            r_commit_pend  <= 1'b0;
            r_px_data      <= '0;
            r_px_valid     <= 1'b0;
            r_latch        <= 1'b0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_timer      <= w_wrap ? '0 : r_timer + TW'(1);

            // A wrap coinciding with a frame start is kept pending so no refresh is dropped.
            if (w_start) begin
                r_commit_pend  <= 1'b0;
                r_refresh_pend <= w_wrap;
            end else begin
                r_commit_pend  <= r_commit_pend | commit;
                r_refresh_pend <= r_refresh_pend | w_wrap;
            end

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state    <= SEND;
                        r_busy     <= 1'b1;
                        r_idx      <= '0;
                        r_px_valid <= 1'b1;
                        r_px_data  <= w_rd_data;
                    end
                end
                SEND: begin
                    if (r_px_valid && px_ready) begin
                        if (r_idx == IDX_LAST) begin
                            r_px_valid <= 1'b0;
                            r_state    <= LATCH;
                            r_latch    <= 1'b1;
                            r_lcnt     <= '0;
                        end else begin
                            r_idx     <= w_next_idx;
                            r_px_data <= w_rd_data;
                        end
                    end
                end
                LATCH: begin
                    if (r_lcnt == LATCH_LAST) begin
                        r_latch      <= 1'b0;
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_lcnt <= r_lcnt + LW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign px_data    = r_px_data;
    assign px_valid   = r_px_valid;
    assign latch      = r_latch;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ws2812b_frame_ctrl.sv
// Directed self-checking bench for ws2812b_frame_ctrl (12 pixels, 1200-cycle latch, 8000-cycle refresh).
module tb_ws2812b_frame_ctrl;
    localparam int LC = 12;
    localparam int RC = 1200;
    localparam int FC = 8000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        commit = 1'b0;
    logic [23:0] px_data;
    logic        px_valid;
    logic        px_ready = 1'b1;
    logic        latch;
    logic        busy;
    logic        frame_done;

    int          checks = 0;
    int          errors = 0;
    string       cur_test = "init";
    logic [23:0] exp_px [LC];

    ws2812b_frame_ctrl #(
        .LED_COUNT    (LC),
        .RESET_CYCLES (RC),
        .FRAME_CYCLES (FC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit     (commit),
        .px_data    (px_data),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .latch      (latch),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s got=%h exp=%h", cur_test, tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(px_valid), 32'd0);
        check({tag, "_data"},  32'(px_data), 32'd0);
        check({tag, "_latch"}, 32'(latch), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(frame_done), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        commit = 1'b0;
        wr_en = 1'b0;
        px_ready = 1'b1;
        tick();
        tick();
        check_all_zero("rst");
        rst = 1'b0;
    endtask

    task automatic write_px(input logic [3:0] a, input logic [23:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < LC; i++) begin
            write_px(4'(i), 24'h000100 + 24'(i));
            exp_px[i] = 24'h000100 + 24'(i);
        end
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    // Entered at the sample where pixel 0 should be presented; leaves one cycle after frame_done.
    task automatic run_frame(input int stall_pix, input int stall_len, input int n_commits);
        int lat;
        int fd;
        px_ready = 1'b1;
        check("busy_send", 32'(busy), 32'd1);
        for (int k = 0; k < LC; k++) begin
            if (k == stall_pix) begin
                px_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check("stall_valid", 32'(px_valid), 32'd1);
                    check("stall_data", 32'(px_data), 32'(exp_px[k]));
                    tick();
                end
                px_ready = 1'b1;
            end
            check("valid", 32'(px_valid), 32'd1);
            check("data", 32'(px_data), 32'(exp_px[k]));
            tick();
        end
        check("valid_drop", 32'(px_valid), 32'd0);
        lat = 0;
        fd = 0;
        while (latch && lat < RC + 50) begin
            commit = (n_commits > 0 && lat == 10) || (n_commits > 1 && lat == 20);
            if (frame_done) fd++;
            lat++;
            tick();
        end
        commit = 1'b0;
        check("latch_len", 32'(lat), 32'(RC));
        check("early_done", 32'(fd), 32'd0);
        check("frame_done", 32'(frame_done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        tick();
        check("done_pulse", 32'(frame_done), 32'd0);
    endtask

    initial begin
        int cnt;
        int vcnt;

        cur_test = "basic";
        do_reset();
        load_ramp();
        do_commit();
        run_frame(-1, 0, 0);

        cur_test = "stall";
        do_reset();
        load_ramp();
        do_commit();
        run_frame(3, 5, 0);

        cur_test = "bad_addr";
        do_reset();
        load_ramp();
        write_px(4'd12, 24'hFFFFFF);
        write_px(4'd15, 24'hFFFFFF);
        do_commit();
        run_frame(-1, 0, 0);

        cur_test = "merge";
        do_reset();
        load_ramp();
        do_commit();
        run_frame(-1, 0, 2);
        check("extra_start", 32'(px_valid), 32'd1);
        run_frame(-1, 0, 0);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (px_valid || busy) vcnt++;
            tick();
        end
        check("no_third", 32'(vcnt), 32'd0);

        cur_test = "mid_rst";
        do_reset();
        load_ramp();
        do_commit();
        for (int i = 0; i < 6; i++) tick();
        check("pix6", 32'(px_data), 32'(exp_px[6]));
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async");
        tick();
        rst = 1'b0;
        cnt = 0;
        while (!px_valid && cnt < FC + 100) begin
            tick();
            cnt++;
        end
        check("refresh_delay", 32'(cnt >= FC && cnt <= FC + 1), 32'd1);
        for (int i = 0; i < LC; i++) exp_px[i] = '0;
        run_frame(-1, 0, 0);

        cur_test = "buffering";
        do_reset();
        load_ramp();
        do_commit();
        run_frame(-1, 0, 0);
        write_px(4'd0, 24'h0000FF);
        cnt = 0;
        while (!px_valid && cnt < FC + 100) begin
            tick();
            cnt++;
        end
        check("refresh_seen", 32'(px_valid), 32'd1);
`ifdef WS2812B_DOUBLE_BUFFER_EN
        exp_px[0] = 24'h000100;
`else
        exp_px[0] = 24'h0000FF;
`endif
        run_frame(-1, 0, 0);
        do_commit();
        exp_px[0] = 24'h0000FF;
        run_frame(-1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
